// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch FIFO between synchronous ROM and core fetch port
module instr_prefetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] FetchAddr,
    input  logic              FetchReq,
    output logic [DATA_W-1:0] InstrData,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] RomAddr,
    output logic              RomReadEn,
    input  logic [DATA_W-1:0] RomData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] fetch_word;
    logic [CW:0]       in_flight;
    logic              redirect, avail, hit, from_fifo, pop, bypass, push, prefetch;

    always_comb begin
        fetch_word = FetchAddr & ALIGN_MASK;
        // Gated by reset so the ROM request drops the moment nReset falls.
        redirect   = nReset && FetchReq && (state_q == IDLE || fetch_word != head_addr_q);
        from_fifo  = (count_q != '0);
        avail      = (state_q == STREAM) && (from_fifo || pend_q);
        hit        = FetchReq && !redirect && avail;
        pop        = hit && from_fifo;
        bypass     = hit && !from_fifo;
        push       = pend_q && !redirect && !bypass;
        in_flight  = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
        // A same-cycle hit frees a slot, so a full buffer can still issue a read.
        prefetch   = (state_q == STREAM) && !redirect && ((in_flight < DEPTH_C) || hit);

        InstrValid = hit;
        InstrData  = hit ? (from_fifo ? mem_q[rd_ptr_q] : RomData) : '0;
        RomReadEn  = redirect || prefetch;
        RomAddr    = redirect ? fetch_word : next_addr_q;

        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        head_addr_d = head_addr_q;
        next_addr_d = next_addr_q;
        pend_d      = pend_q;

        if (redirect) begin
            state_d     = STREAM;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            head_addr_d = fetch_word;
            next_addr_d = fetch_word + WORD_STEP;
            pend_d      = 1'b1;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            pend_d   = prefetch;
            if (hit)      head_addr_d = head_addr_q + WORD_STEP;
            if (prefetch) next_addr_d = next_addr_q + WORD_STEP;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            head_addr_q <= '0;
            next_addr_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            head_addr_q <= head_addr_d;
            next_addr_q <= next_addr_d;
            pend_q      <= pend_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= RomData;
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed and randomized bench for instr_prefetch
module tb_instr_prefetch;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        nReset;
    logic [15:0] FetchAddr;
    logic        FetchReq;
    logic [31:0] InstrData;
    logic        InstrValid;
    logic [15:0] RomAddr;
    logic        RomReadEn;
    logic [31:0] RomData;

    instr_prefetch #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .nReset(nReset), .FetchAddr(FetchAddr), .FetchReq(FetchReq),
        .InstrData(InstrData), .InstrValid(InstrValid), .RomAddr(RomAddr),
        .RomReadEn(RomReadEn), .RomData(RomData)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // ROM emulation state (what the ROM saw on the previous cycle)
    logic        rom_pend;
    logic [15:0] rom_addr;

    // Reference model: words held or in flight, as a plain queue
    bit          m_idle;
    logic [15:0] m_head, m_next, m_pend_addr;
    bit          m_pend;
    logic [31:0] m_q[$];

    logic        last_valid, last_rden;
    logic [31:0] last_data;
    logic [15:0] last_romaddr;
    bit          last_exp_hit;

    function automatic logic [31:0] rom(input logic [15:0] a);
        logic [31:0] w;
        w = 32'(a >> 2);
        return 32'hA000_0000 | w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_pend = 1'b0;
        m_head = '0;
        m_next = '0;
        m_pend_addr = '0;
        m_q.delete();
        rom_pend = 1'b0;
        rom_addr = '0;
    endtask

    task automatic step(input logic req, input logic [15:0] a);
        logic [15:0] aw;
        bit redir, hit, from_q, rd;
        int occ;
        logic [31:0] exp_data;
        logic [15:0] exp_addr;
        @(negedge Clock);
        FetchReq  = req;
        FetchAddr = a;
        RomData   = rom_pend ? rom(rom_addr) : $urandom;
        #1;
        aw     = a & 16'hFFFC;
        redir  = req && (m_idle || aw != m_head);
        from_q = m_q.size() > 0;
        hit    = req && !redir && !m_idle && (from_q || m_pend);
        occ    = m_q.size() + int'(m_pend) - int'(hit);
        rd     = redir || (!m_idle && occ < DEPTH);
        exp_data = hit ? (from_q ? m_q[0] : rom(m_pend_addr)) : 32'h0;
        exp_addr = redir ? aw : m_next;

        check("instr_valid", 32'(InstrValid), 32'(hit));
        check("instr_data", InstrData, exp_data);
        check("rom_read_en", 32'(RomReadEn), 32'(rd));
        if (rd) check("rom_addr", 32'(RomAddr), 32'(exp_addr));

        last_valid = InstrValid; last_data = InstrData;
        last_rden = RomReadEn; last_romaddr = RomAddr; last_exp_hit = hit;
        rom_pend = RomReadEn; rom_addr = RomAddr;

        if (redir) begin
            m_idle = 1'b0;
            m_q.delete();
            m_pend = 1'b1;
            m_pend_addr = aw;
            m_head = aw;
            m_next = aw + 16'd4;
        end else begin
            if (m_pend && !(hit && !from_q)) m_q.push_back(rom(m_pend_addr));
            if (hit && from_q) void'(m_q.pop_front());
            if (hit) m_head = m_head + 16'd4;
            m_pend = rd;
            if (rd) begin
                m_pend_addr = m_next;
                m_next = m_next + 16'd4;
            end
        end
    endtask

    initial begin
        logic [15:0] pc;
        logic [15:0] ra;
        int r;
        nReset = 1'b0; FetchReq = 1'b0; FetchAddr = '0; RomData = '0;
        model_reset();
        #1;
        check("rst_valid", 32'(InstrValid), 32'h0);
        check("rst_data", InstrData, 32'h0);
        check("rst_rden", 32'(RomReadEn), 32'h0);
        check("rst_romaddr", 32'(RomAddr), 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock) nReset = 1'b1;

        // Sequential stream from 0x0000
        pc = 16'h0000;
        step(1'b1, pc);
        check("first_valid", 32'(last_valid), 32'h0);
        check("first_romaddr", 32'(last_romaddr), 32'h0);
        step(1'b1, pc);
        check("word0", last_data, 32'hA000_0000);
        pc += 4;
        step(1'b1, pc);
        check("word1", last_data, 32'hA000_0001);
        pc += 4;

        // Core stalls: buffer fills, reads stop
        repeat (10) step(1'b0, pc);
        check("full_rden", 32'(last_rden), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, pc);
            check("resume_word", last_data, 32'hA000_0002 + 32'(k));
            if (k == 0) check("full_hit_read", 32'(last_rden), 32'h1);
            pc += 4;
        end

        // Non-sequential request
        step(1'b1, 16'h0100);
        check("redir_valid", 32'(last_valid), 32'h0);
        check("redir_romaddr", 32'(last_romaddr), 32'h0100);
        step(1'b1, 16'h0100);
        check("redir_word", last_data, 32'hA000_0040);
        step(1'b1, 16'h0104);
        check("redir_word1", last_data, 32'hA000_0041);

        // Address wrap with no bubble
        step(1'b1, 16'hFFF8);
        pc = 16'hFFF8;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, pc);
            check("wrap_valid", 32'(last_valid), 32'h1);
            check("wrap_word", last_data, rom(pc));
            pc += 4;
        end

        // Asynchronous reset mid-stream
        step(1'b1, pc);
        #2 nReset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(InstrValid), 32'h0);
        check("mid_rst_rden", 32'(RomReadEn), 32'h0);
        check("mid_rst_data", InstrData, 32'h0);
        FetchReq = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock) nReset = 1'b1;
        repeat (3) step(1'b0, 16'h0040);
        check("post_rst_rden", 32'(last_rden), 32'h0);

        // Randomized core behaviour
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       ra = m_head | 16'($urandom_range(0, 3));
            else if (r == 8) ra = 16'($urandom);
            else             ra = m_head + 16'd4;
            step($urandom_range(0, 3) != 0, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
